patch_ctrl: RTL and testbench
=============================

Name: patch_ctrl

Overview:
- Runtime controller for the patch ports of a patched module: sits between `control_port_in` (values from the original logic) and `control_port_out` (values driving the module's outputs and internal nets).
- Per-bit overrides are loaded over a serial configuration channel.
- Overrides take effect only after a trigger pattern on `observe_port` holds for a programmed number of cycles.
- Sequences load → arm → activate → disarm. Pass-through is the default.

Parameters:
- N_CTRL, 4, number of controlled signals (width of the control ports)
- N_OBS, 2, number of observed signals
- HOLD_W, 4, width of the trigger hold counter
- CFG_W, 2*N_CTRL+2*N_OBS+HOLD_W (derived, localparam), config frame length in bits

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  serial config bit valid
- cfg_data  in  1  serial config bit, LSB of frame first
- cfg_last  in  1  marks final bit of frame; qualified by cfg_valid
- cfg_ready  out  1  controller accepts config bits
- disarm  in  1  pulse; return to IDLE, keep config
- control_port_in  in  N_CTRL  unpatched values from design
- control_port_out  out  N_CTRL  patched values to design
- observe_port  in  N_OBS  observed design signals
- patch_active  out  1  overrides currently applied
- cfg_error  out  1  sticky; last frame had wrong length

Behaviour:
- Reset clears the following: state=IDLE, shadow and live config=0, hold counter=0, cfg_error=0, patch_active=0. control_port_out then equals control_port_in (pure pass-through).
- Frame layout, bit 0 first:
  - ovr_en[N_CTRL]
  - ovr_val[N_CTRL]
  - trig_mask[N_OBS]
  - trig_val[N_OBS]
  - hold[HOLD_W]
- States: IDLE, LOAD, ARMED, ACTIVE.
- cfg_ready=1 in IDLE, LOAD and ARMED; 0 in ACTIVE. A bit transfers when cfg_valid&&cfg_ready.
- IDLE or ARMED, on first accepted bit:
  - enter LOAD, bit count=1, shift into shadow register.
  - Live config is untouched, so an ARMED block disarms while loading.
- LOAD, each accepted bit: shift in, count++.
- LOAD, on accepted bit with cfg_last:
  - If count==CFG_W: copy shadow→live next edge, clear cfg_error, go ARMED.
  - Otherwise: set cfg_error, discard shadow, keep old live config, go IDLE.
  - A frame longer than CFG_W is detected at cfg_last the same way.
- Match (combinational): ((observe_port ^ trig_val) & trig_mask)==0. All-zero mask always matches.
- ARMED, hold counter:
  - Increments on each matching cycle; clears on a mismatch.
  - On the cycle where match is true and counter==hold, go ACTIVE. So hold+1 consecutive matches are needed (hold=0 means the first match).
  - Counter saturates, never wraps.
- ACTIVE:
  - patch_active=1 (registered, asserted the cycle after the transition edge).
  - Sticky until disarm.
- disarm:
  - From ARMED or ACTIVE: go IDLE, counter=0.
  - Ignored in IDLE.
  - In LOAD: aborts the frame, no cfg_error.
  - disarm has priority over a simultaneous match or cfg_last.
- Output mux is combinational: control_port_out[i] = (patch_active && ovr_en[i]) ? ovr_val[i] : control_port_in[i]. Zero latency from control_port_in.
- Reset asserted mid-frame or while ACTIVE: outputs return to pass-through immediately (asynchronously); live config is lost.

Optional Feature:
- Macro PATCH_CTRL_TRANSIENT_EN.
- Defined: ACTIVE returns to ARMED (counter=0) on the first non-matching cycle, so the patch applies only while the trigger holds. patch_active drops the next cycle.
- Undefined: ACTIVE is sticky as above.

Decomposition:
- Package patch_pkg holds:
  - state enum (IDLE/LOAD/ARMED/ACTIVE)
  - frame field offset localparams as functions of N_CTRL/N_OBS/HOLD_W
  - config struct typedef
- One sub-module, patch_trigger: match compare, saturating hold counter, hit output. Inputs are mask, val, hold, observe, enable and clear.
- The FSM, shift register and output mux stay in patch_ctrl.

Test Plan (N_CTRL=4, N_OBS=2, HOLD_W=4, CFG_W=16):
- After reset, drive control_port_in=4'b1010 → control_port_out=4'b1010, patch_active=0, cfg_ready=1.
- Load frame en=4'b0011, val=4'b0001, mask=2'b01, val=2'b01, hold=2; hold observe_port=2'b01 → patch_active rises after the 3rd matching cycle; with in=4'b1010, out=4'b1001.
- Same config with observe pattern 01,01,00,01,01,01 → counter restarts at the mismatch; ACTIVE only after the final three matches.
- Send a 15-bit frame with cfg_last → cfg_error=1, state IDLE, previous live config intact; then send a good 16-bit frame → cfg_error=0.
- While ACTIVE, pulse disarm in the same cycle as a match → IDLE, out=in next cycle; cfg_ready=0 during ACTIVE is confirmed beforehand.
- With PATCH_CTRL_TRANSIENT_EN, ACTIVE then observe=2'b00 → patch_active=0 the next cycle, state ARMED. Without the macro, the same stimulus leaves patch_active=1.

Source files
------------

// File: rtl/patch_ctrl_pkg.sv
// Shared types for the patch controller: FSM states, frame field offsets and
// the live configuration record (sized for the default port widths).
package patch_pkg;
  localparam int DEF_N_CTRL = 4;
  localparam int DEF_N_OBS  = 2;
  localparam int DEF_HOLD_W = 4;

  // Frame layout, bit 0 first on the wire
  localparam int OFF_EN   = 0;
  localparam int OFF_VAL  = OFF_EN   + DEF_N_CTRL;
  localparam int OFF_MASK = OFF_VAL  + DEF_N_CTRL;
  localparam int OFF_TVAL = OFF_MASK + DEF_N_OBS;
  localparam int OFF_HOLD = OFF_TVAL + DEF_N_OBS;
  localparam int FRAME_W  = OFF_HOLD + DEF_HOLD_W;

  typedef enum logic [1:0] {IDLE, LOAD, ARMED, ACTIVE} state_t;

  typedef struct packed {
    logic [DEF_HOLD_W-1:0] hold;
    logic [DEF_N_OBS-1:0]  trig_val;
    logic [DEF_N_OBS-1:0]  trig_mask;
    logic [DEF_N_CTRL-1:0] ovr_val;
    logic [DEF_N_CTRL-1:0] ovr_en;
  } cfg_t;
endpackage

// File: rtl/patch_trigger.sv
// Trigger qualifier: masked compare of the observed bus and a saturating
// run-length counter; hit fires on the (hold+1)th consecutive match.
module patch_trigger #(
  parameter int N_OBS  = 2,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_OBS-1:0]  mask,
  input  logic [N_OBS-1:0]  val,
  input  logic [HOLD_W-1:0] hold,
  input  logic [N_OBS-1:0]  observe,
  input  logic              enable,
  input  logic              clear,
  output logic              match,
  output logic              hit
);
  logic [HOLD_W-1:0] cnt;

  assign match = ((observe ^ val) & mask) == '0;
  assign hit   = enable && match && (cnt == hold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt <= '0;
    else if (clear || !enable || !match) cnt <= '0;
    else if (cnt != '1)                  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/patch_ctrl.sv
// Patch-port controller: serial config load, trigger arming and per-bit
// override mux. Build with PATCH_CTRL_TRANSIENT_EN to drop the patch on trigger loss.
module patch_ctrl
  import patch_pkg::*;
#(
  parameter int N_CTRL = DEF_N_CTRL,
  parameter int N_OBS  = DEF_N_OBS,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  input  logic              cfg_data,
  input  logic              cfg_last,
  output logic              cfg_ready,
  input  logic              disarm,
  input  logic [N_CTRL-1:0] control_port_in,
  output logic [N_CTRL-1:0] control_port_out,
  input  logic [N_OBS-1:0]  observe_port,
  output logic              patch_active,
  output logic              cfg_error
);
  localparam int CFG_W = 2*N_CTRL + 2*N_OBS + HOLD_W;
  localparam int CNT_W = $clog2(CFG_W + 2);
`ifdef PATCH_CTRL_TRANSIENT_EN
  localparam bit TRANSIENT = 1'b1;
`else
  localparam bit TRANSIENT = 1'b0;
`endif

  if (CFG_W != $bits(cfg_t)) begin : g_width_check
    $error("patch_ctrl: parameters disagree with patch_pkg frame layout");
  end

  state_t            state, nxt;
  logic [CFG_W-1:0]  shadow, shadow_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  cfg_t              live;
  logic              accept, commit, frame_err, match, hit;
  logic [N_CTRL-1:0] sel;

  assign cfg_ready  = (state != ACTIVE);
  assign accept     = cfg_valid && cfg_ready;
  assign shadow_nxt = {cfg_data, shadow[CFG_W-1:1]};
  // A bit accepted outside LOAD starts a new frame; count saturates so overlong frames stay wrong
  assign cnt_nxt    = (state != LOAD) ? CNT_W'(1) : ((&cnt) ? cnt : cnt + 1'b1);

  patch_trigger #(.N_OBS(N_OBS), .HOLD_W(HOLD_W)) u_trig (
    .clk     (clk),
    .rst_n   (rst_n),
    .mask    (live.trig_mask),
    .val     (live.trig_val),
    .hold    (live.hold),
    .observe (observe_port),
    .enable  (state == ARMED),
    .clear   (disarm),
    .match   (match),
    .hit     (hit)
  );

  always_comb begin
    nxt       = state;
    commit    = 1'b0;
    frame_err = 1'b0;
    if (disarm && state != IDLE) begin
      nxt = IDLE;
    end else if (accept) begin
      if (!cfg_last)                      nxt = LOAD;
      else if (cnt_nxt == CNT_W'(CFG_W)) begin
        nxt    = ARMED;
        commit = 1'b1;
      end else begin
        nxt       = IDLE;
        frame_err = 1'b1;
      end
    end else if (state == ARMED && hit) begin
      nxt = ACTIVE;
    end else if (TRANSIENT && state == ACTIVE && !match) begin
      nxt = ARMED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadow       <= '0;
      cnt          <= '0;
      live         <= '0;
      cfg_error    <= 1'b0;
      patch_active <= 1'b0;
    end else begin
      state        <= nxt;
      patch_active <= (nxt == ACTIVE);
      if (accept) begin
        shadow <= shadow_nxt;
        cnt    <= cnt_nxt;
      end
      if (commit) begin
        live.ovr_en    <= shadow_nxt[OFF_EN   +: N_CTRL];
        live.ovr_val   <= shadow_nxt[OFF_VAL  +: N_CTRL];
        live.trig_mask <= shadow_nxt[OFF_MASK +: N_OBS];
        live.trig_val  <= shadow_nxt[OFF_TVAL +: N_OBS];
        live.hold      <= shadow_nxt[OFF_HOLD +: HOLD_W];
        cfg_error      <= 1'b0;
      end
      if (frame_err) cfg_error <= 1'b1;
    end
  end

  // Override mux is purely combinational so control_port_in has zero latency
  assign sel              = live.ovr_en & {N_CTRL{patch_active}};
  assign control_port_out = (control_port_in & ~sel) | (live.ovr_val & sel);
endmodule

// File: tb/tb_patch_ctrl.sv
// Directed bench for patch_ctrl: vector tables for trigger/override sequences
// plus hand sequences for framing errors, disarm and async reset.
module tb_patch_ctrl;
  import patch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0, cfg_data = 1'b0, cfg_last = 1'b0, disarm = 1'b0;
  logic [3:0] control_port_in = 4'b1010;
  logic [1:0] observe_port = 2'b00;
  logic [3:0] control_port_out;
  logic       cfg_ready, patch_active, cfg_error;

  int errors = 0;
  int checks = 0;

  patch_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_valid        (cfg_valid),
    .cfg_data         (cfg_data),
    .cfg_last         (cfg_last),
    .cfg_ready        (cfg_ready),
    .disarm           (disarm),
    .control_port_in  (control_port_in),
    .control_port_out (control_port_out),
    .observe_port     (observe_port),
    .patch_active     (patch_active),
    .cfg_error        (cfg_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    logic [1:0] obs;
    logic       exp_act;
    logic [3:0] exp_out;
  } vec_t;

  // en=0011 val=0001 mask=01 tval=01 hold=2
  localparam logic [15:0] FRAME_A = 16'h2513;
  // en=0011 val=0001 mask=00 tval=00 hold=1
  localparam logic [15:0] FRAME_B = 16'h1013;
  // FRAME_A with hold=0
  localparam logic [15:0] FRAME_C = 16'h0513;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] f, input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = f[i];
      cfg_last  = with_last && (i == len - 1);
      step();
    end
    cfg_valid = 1'b0;
    cfg_data  = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    control_port_in = v.in;
    observe_port    = v.obs;
    step();
    chk({tag, ".active"}, 32'(patch_active), 32'(v.exp_act));
    chk({tag, ".out"}, 32'(control_port_out), 32'(v.exp_out));
  endtask

  task automatic pulse_disarm();
    disarm = 1'b1;
    step();
    disarm = 1'b0;
  endtask

  vec_t arm_tbl[6];
  vec_t restart_tbl[6];

  initial begin
    arm_tbl[0] = '{4'b1010, 2'b01, 1'b0, 4'b1010};
    arm_tbl[1] = '{4'b1010, 2'b01, 1'b0, 4'b1010};
    arm_tbl[2] = '{4'b1010, 2'b01, 1'b1, 4'b1001};
    arm_tbl[3] = '{4'b0000, 2'b01, 1'b1, 4'b0001};
    arm_tbl[4] = '{4'b1111, 2'b01, 1'b1, 4'b1101};
    arm_tbl[5] = '{4'b0110, 2'b01, 1'b1, 4'b0101};

    restart_tbl[0] = '{4'b1010, 2'b01, 1'b0, 4'b1010};
    restart_tbl[1] = '{4'b1010, 2'b01, 1'b0, 4'b1010};
    restart_tbl[2] = '{4'b1010, 2'b00, 1'b0, 4'b1010};
    restart_tbl[3] = '{4'b1010, 2'b01, 1'b0, 4'b1010};
    restart_tbl[4] = '{4'b1010, 2'b01, 1'b0, 4'b1010};
    restart_tbl[5] = '{4'b1010, 2'b01, 1'b1, 4'b1001};

    // Reset state and pass-through
    #12;
    chk("rst.out", 32'(control_port_out), 32'h0000000A);
    chk("rst.active", 32'(patch_active), 32'd0);
    chk("rst.ready", 32'(cfg_ready), 32'd1);
    chk("rst.err", 32'(cfg_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Load, hold=2 needs three matches, then overrides on several inputs
    observe_port = 2'b01;
    send(FRAME_A, 16, 1'b1);
    chk("load.state", 32'(dut.state), 32'(ARMED));
    for (int i = 0; i < 6; i++) apply(arm_tbl[i], $sformatf("arm%0d", i));
    chk("active.ready", 32'(cfg_ready), 32'd0);

    // Trigger loss while ACTIVE
    control_port_in = 4'b1010;
    observe_port    = 2'b00;
    step();
`ifdef PATCH_CTRL_TRANSIENT_EN
    chk("loss.active", 32'(patch_active), 32'd0);
    chk("loss.state", 32'(dut.state), 32'(ARMED));
`else
    chk("loss.active", 32'(patch_active), 32'd1);
    chk("loss.state", 32'(dut.state), 32'(ACTIVE));
`endif
    observe_port = 2'b01;
    step(); step(); step();
    chk("reactive.active", 32'(patch_active), 32'd1);

    // Disarm with simultaneous match
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    chk("disarm.state", 32'(dut.state), 32'(IDLE));
    chk("disarm.active", 32'(patch_active), 32'd0);
    chk("disarm.out", 32'(control_port_out), 32'h0000000A);

    // Mismatch mid-run restarts the hold count
    send(FRAME_A, 16, 1'b1);
    for (int i = 0; i < 6; i++) apply(restart_tbl[i], $sformatf("restart%0d", i));
    pulse_disarm();

    // Short frame: error, IDLE, live config kept; then a good frame clears the error
    send(16'h7FFF, 15, 1'b1);
    chk("short.err", 32'(cfg_error), 32'd1);
    chk("short.state", 32'(dut.state), 32'(IDLE));
    chk("short.live", 32'(dut.live), 32'(FRAME_A));
    send(16'h7FFF, 16, 1'b0);
    send(16'h0001, 2, 1'b1);
    chk("long.err", 32'(cfg_error), 32'd1);
    chk("long.state", 32'(dut.state), 32'(IDLE));
    observe_port = 2'b10;
    send(FRAME_B, 16, 1'b1);
    chk("good.err", 32'(cfg_error), 32'd0);
    chk("good.state", 32'(dut.state), 32'(ARMED));
    chk("good.live", 32'(dut.live), 32'(FRAME_B));
    // All-zero mask matches any observe value; hold=1 needs two cycles
    step();
    chk("mask0.c1", 32'(patch_active), 32'd0);
    step();
    chk("mask0.c2", 32'(patch_active), 32'd1);
    chk("mask0.out", 32'(control_port_out), 32'h00000009);
    pulse_disarm();

    // Disarm during LOAD aborts without error
    send(FRAME_A, 5, 1'b0);
    chk("abort.pre", 32'(dut.state), 32'(LOAD));
    pulse_disarm();
    chk("abort.state", 32'(dut.state), 32'(IDLE));
    chk("abort.err", 32'(cfg_error), 32'd0);
    chk("abort.live", 32'(dut.live), 32'(FRAME_B));

    // hold=0 activates on the first match
    observe_port = 2'b01;
    send(FRAME_C, 16, 1'b1);
    step();
    chk("hold0.active", 32'(patch_active), 32'd1);

    // Async reset while ACTIVE returns to pass-through immediately
    control_port_in = 4'b0110;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.active", 32'(patch_active), 32'd0);
    chk("areset.out", 32'(control_port_out), 32'h00000006);
    chk("areset.live", 32'(dut.live), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
